// File: rtl/arm_cpu.sv
// Single-cycle 64-bit LEGv8-subset core: PC, 32x64 register file, combinational decode/execute.
// Optional MUL instruction is compiled in when the MUL_EN macro is defined.
module arm_cpu #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic        RESET,
  input  logic        CLOCK,
  input  logic [31:0] instruction,
  input  logic [63:0] mem_rdata,
  output logic [63:0] PC,
  output logic [63:0] mem_address,
  output logic [63:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read
);

  localparam int unsigned XLEN   = 64;
  localparam int unsigned RIDX_W = 5;
  localparam logic [RIDX_W-1:0] XZR = RIDX_W'(31);

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_EOR  = 11'b11101010000;
  localparam logic [10:0] OP_LSL  = 11'b11010011011;
  localparam logic [10:0] OP_LSR  = 11'b11010011010;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
`ifdef MUL_EN
  localparam logic [10:0] OP_MUL  = 11'b10011011000;
`endif
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [9:0]  OP_ANDI = 10'b1001001000;
  localparam logic [9:0]  OP_ORRI = 10'b1011001000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [5:0]  OP_B    = 6'b000101;

  logic [XLEN-1:0]   regs [NUM_REGS];
  logic [RIDX_W-1:0] rd, rn, rm;
  logic [5:0]        shamt;
  logic [10:0]       op11;
  logic [9:0]        op10;
  logic [7:0]        op8;
  logic [5:0]        op6;
  logic [XLEN-1:0]   rn_val, rm_val, rt_val;
  logic [XLEN-1:0]   imm12, dt, cb_off, b_off;
  logic [XLEN-1:0]   alu, wr_data, next_pc;
  logic              wr_en, is_load, is_store;

  // Instruction field extraction
  assign rd     = instruction[4:0];
  assign rn     = instruction[9:5];
  assign rm     = instruction[20:16];
  assign shamt  = instruction[15:10];
  assign op11   = instruction[31:21];
  assign op10   = instruction[31:22];
  assign op8    = instruction[31:24];
  assign op6    = instruction[31:26];
  assign imm12  = {52'b0, instruction[21:10]};
  assign dt     = {{55{instruction[20]}}, instruction[20:12]};
  assign cb_off = {{43{instruction[23]}}, instruction[23:5], 2'b00};
  assign b_off  = {{36{instruction[25]}}, instruction[25:0], 2'b00};

  // X31 always reads as zero
  assign rn_val = (rn == XZR) ? '0 : regs[rn];
  assign rm_val = (rm == XZR) ? '0 : regs[rm];
  assign rt_val = (rd == XZR) ? '0 : regs[rd];

  // Decode and execute
  always_comb begin
    alu      = rn_val + rm_val;
    wr_en    = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    next_pc  = PC + XLEN'(4);
    case (op11)
      OP_ADD:  begin alu = rn_val + rm_val;  wr_en = 1'b1; end
      OP_SUB:  begin alu = rn_val - rm_val;  wr_en = 1'b1; end
      OP_AND:  begin alu = rn_val & rm_val;  wr_en = 1'b1; end
      OP_ORR:  begin alu = rn_val | rm_val;  wr_en = 1'b1; end
      OP_EOR:  begin alu = rn_val ^ rm_val;  wr_en = 1'b1; end
      OP_LSL:  begin alu = rn_val << shamt;  wr_en = 1'b1; end
      OP_LSR:  begin alu = rn_val >> shamt;  wr_en = 1'b1; end
`ifdef MUL_EN
      OP_MUL:  begin alu = rn_val * rm_val;  wr_en = 1'b1; end
`endif
      OP_LDUR: begin alu = rn_val + dt; wr_en = 1'b1; is_load = 1'b1; end
      OP_STUR: begin alu = rn_val + dt; is_store = 1'b1; end
      default: begin
        case (op10)
          OP_ADDI: begin alu = rn_val + imm12; wr_en = 1'b1; end
          OP_SUBI: begin alu = rn_val - imm12; wr_en = 1'b1; end
          OP_ANDI: begin alu = rn_val & imm12; wr_en = 1'b1; end
          OP_ORRI: begin alu = rn_val | imm12; wr_en = 1'b1; end
          default: begin
            if ((op8 == OP_CBZ && rt_val == '0) || (op8 == OP_CBNZ && rt_val != '0))
              next_pc = PC + cb_off;
            else if (op6 == OP_B)
              next_pc = PC + b_off;
          end
        endcase
      end
    endcase
  end

  assign wr_data     = is_load ? mem_rdata : alu;
  assign mem_address = alu;
  assign mem_wdata   = rt_val;
  assign mem_read    = is_load & ~RESET;
  assign mem_write   = is_store & ~RESET;

  // Architectural state commit; writes to XZR are dropped
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      PC <= RESET_PC;
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
    end else begin
      PC <= next_pc;
      if (wr_en && rd != XZR) regs[rd] <= wr_data;
    end
  end

endmodule

// File: tb/tb_arm_cpu.sv
// Directed bench for arm_cpu: ISA-level reference model checked every cycle plus literal checks.
module tb_arm_cpu;

  logic        RESET, CLOCK;
  logic [31:0] instruction;
  logic [63:0] mem_rdata;
  logic [63:0] PC, mem_address, mem_wdata;
  logic        mem_write, mem_read;

  int total = 0;
  int bad   = 0;

  logic [63:0] m_x [32];
  logic [63:0] m_pc;

  localparam logic [10:0] ADD = 11'b10001011000, SUB = 11'b11001011000, AND_ = 11'b10001010000;
  localparam logic [10:0] ORR = 11'b10101010000, EOR = 11'b11101010000, LSL = 11'b11010011011;
  localparam logic [10:0] LSR = 11'b11010011010, LDUR = 11'b11111000010, STUR = 11'b11111000000;
  localparam logic [10:0] MUL = 11'b10011011000;
  localparam logic [9:0]  ADDI = 10'b1001000100, SUBI = 10'b1101000100;
  localparam logic [9:0]  ANDI = 10'b1001001000, ORRI = 10'b1011001000;
  localparam logic [7:0]  CBZ = 8'b10110100, CBNZ = 8'b10110101;
`ifdef MUL_EN
  localparam logic [63:0] MUL_X3 = 64'd42;
`else
  localparam logic [63:0] MUL_X3 = 64'd1;
`endif

  arm_cpu dut (
    .RESET(RESET), .CLOCK(CLOCK), .instruction(instruction), .mem_rdata(mem_rdata),
    .PC(PC), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_read(mem_read)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] r_ins(input logic [10:0] op, input logic [4:0] rd, rn, rm,
                                        input logic [5:0] sh);
    return {op, rm, sh, rn, rd};
  endfunction
  function automatic logic [31:0] i_ins(input logic [9:0] op, input logic [4:0] rd, rn,
                                        input logic [11:0] imm);
    return {op, imm, rn, rd};
  endfunction
  function automatic logic [31:0] d_ins(input logic [10:0] op, input logic [4:0] rt, rn,
                                        input logic [8:0] off);
    return {op, off, 2'b00, rn, rt};
  endfunction
  function automatic logic [31:0] cb_ins(input logic [7:0] op, input logic [4:0] rt,
                                         input logic [18:0] off);
    return {op, off, rt};
  endfunction
  function automatic logic [31:0] b_ins(input logic [25:0] off);
    return {6'b000101, off};
  endfunction

  function automatic logic [63:0] xr(input logic [4:0] i);
    return (i == 5'd31) ? 64'd0 : m_x[i];
  endfunction

  // ISA-level semantics of one instruction against the model state
  task automatic model_eval(input logic [31:0] ins, input logic [63:0] rdata,
                            output logic [63:0] npc, output logic we, output logic [63:0] wval,
                            output logic ld, output logic st, output logic [63:0] ea);
    logic [63:0] a, b, imm;
    a = xr(ins[9:5]);
    b = xr(ins[20:16]);
    imm = 64'(ins[21:10]);
    npc = m_pc + 64'd4;
    we = 1'b0; wval = 64'd0; ld = 1'b0; st = 1'b0; ea = 64'd0;
    casez (ins)
      32'b10001011000_?????_??????_?????_?????: begin we = 1; wval = a + b; end
      32'b11001011000_?????_??????_?????_?????: begin we = 1; wval = a - b; end
      32'b10001010000_?????_??????_?????_?????: begin we = 1; wval = a & b; end
      32'b10101010000_?????_??????_?????_?????: begin we = 1; wval = a | b; end
      32'b11101010000_?????_??????_?????_?????: begin we = 1; wval = a ^ b; end
      32'b11010011011_?????_??????_?????_?????: begin we = 1; wval = a << ins[15:10]; end
      32'b11010011010_?????_??????_?????_?????: begin we = 1; wval = a >> ins[15:10]; end
`ifdef MUL_EN
      32'b10011011000_?????_??????_?????_?????: begin we = 1; wval = a * b; end
`endif
      32'b1001000100_????????????_?????_?????: begin we = 1; wval = a + imm; end
      32'b1101000100_????????????_?????_?????: begin we = 1; wval = a - imm; end
      32'b1001001000_????????????_?????_?????: begin we = 1; wval = a & imm; end
      32'b1011001000_????????????_?????_?????: begin we = 1; wval = a | imm; end
      32'b11111000010_?????????_??_?????_?????: begin
        ld = 1; we = 1; wval = rdata; ea = a + 64'($signed(ins[20:12]));
      end
      32'b11111000000_?????????_??_?????_?????: begin
        st = 1; ea = a + 64'($signed(ins[20:12]));
      end
      32'b10110100_???????????????????_?????:
        if (xr(ins[4:0]) == 64'd0) npc = m_pc + 64'($signed(ins[23:5])) * 64'd4;
      32'b10110101_???????????????????_?????:
        if (xr(ins[4:0]) != 64'd0) npc = m_pc + 64'($signed(ins[23:5])) * 64'd4;
      32'b000101_??????????????????????????:
        npc = m_pc + 64'($signed(ins[25:0])) * 64'd4;
      default: ;
    endcase
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle comparison of every meaningful output against the model
  task automatic cycle_check();
    logic [63:0] npc, wval, ea;
    logic we, ld, st;
    model_eval(instruction, mem_rdata, npc, we, wval, ld, st, ea);
    if (RESET) begin ld = 1'b0; st = 1'b0; end
    chk("pc", PC, m_pc);
    chk("mem_wdata", mem_wdata, xr(instruction[4:0]));
    chk("mem_read", 64'(mem_read), 64'(ld));
    chk("mem_write", 64'(mem_write), 64'(st));
    chk("strobe_excl", 64'(mem_read & mem_write), 64'd0);
    if (ld || st) chk("mem_address", mem_address, ea);
  endtask

  task automatic model_step();
    logic [63:0] npc, wval, ea;
    logic we, ld, st;
    if (RESET) begin
      m_pc = 64'd0;
      for (int i = 0; i < 32; i++) m_x[i] = 64'd0;
    end else begin
      model_eval(instruction, mem_rdata, npc, we, wval, ld, st, ea);
      if (we && instruction[4:0] != 5'd31) m_x[instruction[4:0]] = wval;
      m_pc = npc;
    end
  endtask

  task automatic drive(input logic rst, input logic [31:0] ins, input logic [63:0] rd);
    RESET = rst; instruction = ins; mem_rdata = rd;
    @(negedge CLOCK);
    cycle_check();
  endtask

  task automatic commit();
    @(posedge CLOCK);
    model_step();
    #1;
  endtask

  task automatic run(input logic [31:0] ins);
    drive(1'b0, ins, 64'd0);
    commit();
  endtask

  // A zero-opcode word is a NOP whose Rt field exposes X[idx] on mem_wdata
  task automatic peek(input logic [4:0] idx, input logic [63:0] exp, input string name);
    drive(1'b0, {27'b0, idx}, 64'd0);
    chk(name, mem_wdata, exp);
    commit();
  endtask

  initial begin
    RESET = 1'b1; instruction = 32'd0; mem_rdata = 64'd0;
    commit();

    // Reset held with random instructions
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, $urandom, 64'hFFFF);
      chk("reset_pc", PC, 64'd0);
      chk("reset_mem_write", 64'(mem_write), 64'd0);
      chk("reset_mem_read", 64'(mem_read), 64'd0);
      commit();
    end
    drive(1'b0, r_ins(ADD, 1, 2, 3, 0), 64'd0);
    chk("first_pc", PC, 64'd0);
    commit();
    drive(1'b0, {27'b0, 5'd1}, 64'd0);
    chk("pc_after_add", PC, 64'd4);
    chk("x1_after_reset", mem_wdata, 64'd0);
    commit();

    // ALU operations
    run(i_ins(ADDI, 1, 31, 12'd5));
    run(i_ins(ADDI, 2, 31, 12'd3));
    run(r_ins(SUB, 3, 1, 2, 0));
    run(r_ins(LSL, 4, 1, 0, 6'd4));
    run(r_ins(EOR, 5, 1, 2, 0));
    run(i_ins(SUBI, 6, 31, 12'd1));
    run(r_ins(AND_, 7, 1, 2, 0));
    run(r_ins(ORR, 8, 1, 2, 0));
    run(r_ins(LSR, 9, 4, 0, 6'd2));
    run(i_ins(ANDI, 10, 5, 12'd4));
    run(i_ins(ORRI, 11, 1, 12'h010));
    run(r_ins(ADD, 12, 6, 1, 0));
    peek(3, 64'd2, "sub");
    peek(4, 64'd80, "lsl");
    peek(5, 64'd6, "eor");
    peek(6, 64'hFFFF_FFFF_FFFF_FFFF, "subi_wrap");
    peek(7, 64'd1, "and");
    peek(8, 64'd7, "orr");
    peek(9, 64'd20, "lsr");
    peek(10, 64'd4, "andi");
    peek(11, 64'h15, "orri");
    peek(12, 64'd4, "add_wrap");
    run(r_ins(ADD, 1, 1, 1, 0));
    peek(1, 64'd10, "self_read");

    // Loads and stores
    run(i_ins(ADDI, 1, 31, 12'd16));
    run(i_ins(ADDI, 2, 31, 12'hABC));
    run(r_ins(LSL, 2, 2, 0, 6'd4));
    run(i_ins(ORRI, 2, 2, 12'h00D));
    drive(1'b0, d_ins(STUR, 2, 1, 9'd8), 64'd0);
    chk("stur_write", 64'(mem_write), 64'd1);
    chk("stur_read", 64'(mem_read), 64'd0);
    chk("stur_addr", mem_address, 64'd24);
    chk("stur_wdata", mem_wdata, 64'hABCD);
    commit();
    drive(1'b0, d_ins(LDUR, 3, 1, 9'd8), 64'hABCD);
    chk("ldur_read", 64'(mem_read), 64'd1);
    chk("ldur_write", 64'(mem_write), 64'd0);
    chk("ldur_addr", mem_address, 64'd24);
    commit();
    peek(3, 64'hABCD, "ldur_data");
    drive(1'b0, d_ins(LDUR, 4, 1, 9'(-8)), 64'h1234);
    chk("ldur_neg_addr", mem_address, 64'd8);
    commit();
    peek(4, 64'h1234, "ldur_neg_data");
    drive(1'b0, d_ins(LDUR, 31, 1, 9'd0), 64'd99);
    commit();
    peek(31, 64'd0, "ldur_xzr");

    // Reset in the middle of a program
    drive(1'b1, d_ins(STUR, 2, 1, 9'd8), 64'd0);
    chk("reset_blocks_store", 64'(mem_write), 64'd0);
    commit();
    drive(1'b1, i_ins(ADDI, 5, 31, 12'd9), 64'd0);
    commit();
    drive(1'b0, {27'b0, 5'd3}, 64'd0);
    chk("midreset_pc", PC, 64'd0);
    chk("midreset_x3", mem_wdata, 64'd0);
    commit();

    // Branches (PC=4 here)
    run(i_ins(ADDI, 1, 31, 12'd1));
    drive(1'b0, cb_ins(CBZ, 0, 19'd3), 64'd0);
    chk("cbz_pc", PC, 64'd8);
    commit();
    drive(1'b0, b_ins(26'(-2)), 64'd0);
    chk("cbz_taken", PC, 64'd20);
    commit();
    drive(1'b0, cb_ins(CBNZ, 0, 19'd5), 64'd0);
    chk("b_back", PC, 64'd12);
    commit();
    drive(1'b0, cb_ins(CBNZ, 1, 19'(-4)), 64'd0);
    chk("cbnz_not_taken", PC, 64'd16);
    commit();
    drive(1'b0, cb_ins(CBZ, 1, 19'd4), 64'd0);
    chk("cbnz_taken", PC, 64'd0);
    commit();
    drive(1'b0, b_ins(26'(-2)), 64'd0);
    chk("cbz_not_taken", PC, 64'd4);
    commit();
    drive(1'b0, 32'h0000_0000, 64'd0);
    chk("pc_wrap_down", PC, 64'hFFFF_FFFF_FFFF_FFFC);
    commit();
    drive(1'b0, 32'hFFFF_FFFF, 64'd0);
    chk("nop_wrap_up", PC, 64'd0);
    chk("unknown_no_write", 64'(mem_write), 64'd0);
    commit();

    // XZR behaviour
    run(i_ins(ADDI, 31, 31, 12'd7));
    run(r_ins(ADD, 1, 31, 31, 0));
    peek(1, 64'd0, "xzr_sum");
    peek(31, 64'd0, "xzr_read");

    // Optional multiply
    run(i_ins(ADDI, 1, 31, 12'd7));
    run(i_ins(ADDI, 2, 31, 12'd6));
    run(i_ins(ADDI, 3, 31, 12'd1));
    run(r_ins(MUL, 3, 1, 2, 0));
    peek(3, MUL_X3, "mul");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arm_cpu.md
Name: arm_cpu

Overview:
Single-issue, single-cycle 64-bit LEGv8-subset processor core. One instruction completes per CLOCK edge. Instruction fetch goes to the external combinational instruction cache (IC) via PC/instruction. Loads and stores go to the external combinational Data_Memory via address, write-data, read-data and read/write strobes. The core holds the PC and a 32x64 register file internally.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset
NUM_REGS, 32, architectural registers; X31 is XZR (always reads 0, writes ignored)

Ports:
Port order is positional and fixed as listed (RESET before CLOCK).
RESET  in  1  synchronous active-high reset, sampled on CLOCK rising edge
CLOCK  in  1  single clock; all state updates on rising edge
instruction  in  32  instruction word at PC, combinational from IC
mem_rdata  in  64  load data from Data_Memory, combinational
PC  out  64  current program counter (registered)
mem_address  out  64  byte address for data memory
mem_wdata  out  64  store data
mem_write  out  1  store strobe
mem_read  out  1  load strobe

Behaviour:
- Reset: RESET=1 at posedge -> PC<=RESET_PC, all registers<=0. While RESET=1: mem_write=0, mem_read=0, no register write. Reset mid-program discards the in-flight instruction.
- Each posedge with RESET=0 commits the instruction currently on `instruction`: register write plus PC update. Latency 1 cycle per instruction.
- Fields: Rd/Rt=[4:0], Rn=[9:5], Rm=[20:16], shamt=[15:10], imm12=[21:10] (zero-extended), DT=[20:12] (sign-extended), CB offset=[23:5], B offset=[25:0].
- R-type, op[31:21], Rd=Rn op Rm:
  - ADD 10001011000
  - SUB 11001011000
  - AND 10001010000
  - ORR 10101010000
  - EOR 11101010000
  - LSL 11010011011 (Rn<<shamt)
  - LSR 11010011010 (Rn>>shamt, logical)
- I-type, op[31:22], Rd=Rn op imm12: ADDI 1001000100, SUBI 1101000100, ANDI 1001001000, ORRI 1011001000.
- Loads and stores:
  - LDUR 11111000010: mem_address=Rn+DT, mem_read=1, Rt<=mem_rdata.
  - STUR 11111000000: mem_address=Rn+DT, mem_wdata=X[Rt], mem_write=1 for that cycle only.
- Branches:
  - CBZ op[31:24]=10110100: if X[Rt]==0, PC<=PC+(sext(offset)<<2).
  - CBNZ 10110101: taken if X[Rt]!=0.
  - B op[31:26]=000101: PC<=PC+(sext(imm26)<<2). All branch targets are relative to the branch's own PC.
- Otherwise PC<=PC+4. All arithmetic is modulo 2^64; PC wraps silently.
- Any unrecognised encoding executes as NOP: PC+4, no writes, strobes 0.
- mem_address always shows the ALU result. mem_wdata always shows X[Rt]. Only the strobes qualify them.
- mem_read and mem_write are never both 1.
- Reading X31 returns 0. A write to Rd=31 is dropped. A destination register read by the same instruction sees its old value.

Optional Feature:
MUL_EN: when defined, R-type MUL op 10011011000 writes the low 64 bits of Rn*Rm to Rd. When undefined, that encoding is a NOP.

Test Plan:
- Reset: hold RESET=1 for 2 edges with random instruction -> PC=0, strobes 0; then ADD X1,X2,X3 -> X1=0, PC=4.
- ALU: ADDI X1,XZR,#5; ADDI X2,XZR,#3; SUB X3,X1,X2; LSL X4,X1,#4; EOR X5,X1,X2 -> X3=2, X4=80, X5=6; SUBI X6,XZR,#1 -> X6=64'hFFFF_FFFF_FFFF_FFFF.
- Memory: X1=16, X2=0xABCD; STUR X2,[X1,#8] -> mem_address=24, mem_wdata=0xABCD, mem_write=1 one cycle; LDUR X3,[X1,#8] with mem_rdata=0xABCD -> mem_read=1, X3=0xABCD.
- Branches: CBZ X0,#3 at PC=8 with X0=0 -> PC=20. CBNZ X0 with X0=0 -> PC+4. B #-2 at PC=20 -> PC=12.
- XZR/NOP: ADDI X31,XZR,#7 then ADD X1,X31,X31 -> X1=0. Instruction 0x00000000 -> PC+4 only.
- MUL_EN build: X1=7, X2=6, MUL X3,X1,X2 -> X3=42. Non-MUL_EN build -> X3 unchanged.
